// File: rtl/irq_request_latch.sv
// Interrupt front end: synchronise/capture lines, feed the priority encoder, and run a
// one-at-a-time req/ack/eoi handshake; Irq_Req rises 3 cycles after capture, no preemption.
`timescale 1ns/1ps
module irq_request_latch #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Irq_In,
  input  logic [7:0] Mask,
  input  logic       Global_En,
  output logic [7:0] Pending,
  output logic       Enc_Enable,
  input  logic [2:0] Enc_Index,
  input  logic       Enc_Valid,
  output logic       Irq_Req,
  input  logic       Irq_Ack,
  output logic [2:0] Ack_Index,
  input  logic       Eoi,
  output logic [7:0] In_Service,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e     state_q, state_d;
  logic [7:0] sync1_q, sync2_q, sync2_dly_q;
  logic [7:0] edge_pend_q, edge_pend_d;
  logic [7:0] raw_pend;
  logic [2:0] cur_q, cur_d;
  logic [2:0] ack_idx_q, ack_idx_d;
  logic [7:0] in_svc_q, in_svc_d;
  logic       enc_hit, ack_take, withdraw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync2_dly_q <= '0;
      edge_pend_q <= '0;
      state_q     <= IDLE;
      cur_q       <= '0;
      ack_idx_q   <= '0;
      in_svc_q    <= '0;
    end else begin
      sync1_q     <= Irq_In;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
      edge_pend_q <= edge_pend_d;
      state_q     <= state_d;
      cur_q       <= cur_d;
      ack_idx_q   <= ack_idx_d;
      in_svc_q    <= in_svc_d;
    end
  end

  assign ack_take = (state_q == REQ) && Irq_Ack;

  // New edge is OR-ed in after the ack clear so a coincident event is never lost.
  always_comb begin
    edge_pend_d = edge_pend_q;
    if (ack_take) edge_pend_d[cur_q] = 1'b0;
    edge_pend_d = edge_pend_d | (sync2_q & ~sync2_dly_q);
  end

  assign raw_pend   = EDGE ? edge_pend_q : sync2_q;
  assign Pending    = raw_pend & Mask;
  assign Enc_Enable = Global_En && (state_q == IDLE);
  // Encoder outputs are stale or don't-care unless it is enabled and reporting valid.
  assign enc_hit    = Enc_Enable && Enc_Valid;
  assign withdraw   = (state_q == REQ) && !Irq_Ack && (!Pending[cur_q] || !Global_En);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ack_idx_d = ack_idx_q;
    in_svc_d  = in_svc_q;
    case (state_q)
      IDLE: begin
        if (enc_hit) begin
          state_d = REQ;
          cur_d   = Enc_Index;
        end
      end
      REQ: begin
        if (Irq_Ack) begin
          state_d   = SERVICE;
          in_svc_d  = 8'd1 << cur_q;
          ack_idx_d = cur_q;
        end else if (withdraw) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (Eoi) begin
          state_d  = IDLE;
          in_svc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Irq_Req    = (state_q == REQ);
  assign Busy       = (state_q != IDLE);
  assign Ack_Index  = ack_idx_q;
  assign In_Service = in_svc_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench: edge-mode and level-mode instances, each fed by a behavioural priority encoder.
`timescale 1ns/1ps
module tb_irq_request_latch;

  logic       clk, rst_n;
  logic [7:0] mask;
  logic       glb_en;
  logic [7:0] irq_in, pend, in_svc;
  logic       enc_en, enc_vld, req, ack, eoi, busy;
  logic [2:0] enc_idx, ack_idx;
  logic [7:0] irq_in0, pend0, in_svc0;
  logic       enc_en0, enc_vld0, req0, ack0, eoi0, busy0;
  logic [2:0] enc_idx0, ack_idx0;
  int vecs = 0;
  int errs = 0;

  function automatic logic [2:0] msb(input logic [7:0] v);
    msb = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) msb = i[2:0];
  endfunction

  // Encoder model never gates Valid with Enable; the DUT must qualify it.
  assign enc_idx  = msb(pend);
  assign enc_vld  = |pend;
  assign enc_idx0 = msb(pend0);
  assign enc_vld0 = |pend0;

  irq_request_latch #(.EDGE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .Irq_In(irq_in), .Mask(mask), .Global_En(glb_en),
    .Pending(pend), .Enc_Enable(enc_en), .Enc_Index(enc_idx), .Enc_Valid(enc_vld),
    .Irq_Req(req), .Irq_Ack(ack), .Ack_Index(ack_idx), .Eoi(eoi),
    .In_Service(in_svc), .Busy(busy));

  irq_request_latch #(.EDGE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .Irq_In(irq_in0), .Mask(mask), .Global_En(glb_en),
    .Pending(pend0), .Enc_Enable(enc_en0), .Enc_Index(enc_idx0), .Enc_Valid(enc_vld0),
    .Irq_Req(req0), .Irq_Ack(ack0), .Ack_Index(ack_idx0), .Eoi(eoi0),
    .In_Service(in_svc0), .Busy(busy0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    vecs++; if (req !== 1'b0) begin errs++; $display("FAIL rst_req act=%0b exp=0", req); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy act=%0b exp=0", busy); end
    vecs++; if (in_svc !== 8'h00) begin errs++; $display("FAIL rst_insvc act=%h exp=00", in_svc); end
    vecs++; if (ack_idx !== 3'd0) begin errs++; $display("FAIL rst_ackidx act=%0d exp=0", ack_idx); end
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL rst_pend act=%h exp=00", pend); end
    vecs++; if (req0 !== 1'b0) begin errs++; $display("FAIL rst_req0 act=%0b exp=0", req0); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_line();
    irq_in = 8'h08; step(); irq_in = 8'h00; step();
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL sl_pend_early act=%h exp=00", pend); end
    step();
    vecs++; if (pend !== 8'h08) begin errs++; $display("FAIL sl_pend act=%h exp=08", pend); end
    vecs++; if (req !== 1'b0) begin errs++; $display("FAIL sl_req_early act=%0b exp=0", req); end
    step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL sl_req act=%0b exp=1", req); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL sl_busy act=%0b exp=1", busy); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (req !== 1'b0) begin errs++; $display("FAIL sl_req_ack act=%0b exp=0", req); end
    vecs++; if (ack_idx !== 3'd3) begin errs++; $display("FAIL sl_ackidx act=%0d exp=3", ack_idx); end
    vecs++; if (in_svc !== 8'h08) begin errs++; $display("FAIL sl_insvc act=%h exp=08", in_svc); end
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL sl_pend_clr act=%h exp=00", pend); end
    step();
    eoi = 1'b1; step(); eoi = 1'b0;
    vecs++; if (in_svc !== 8'h00) begin errs++; $display("FAIL sl_insvc_eoi act=%h exp=00", in_svc); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL sl_busy_eoi act=%0b exp=0", busy); end
    vecs++; if (ack_idx !== 3'd3) begin errs++; $display("FAIL sl_ackidx_hold act=%0d exp=3", ack_idx); end
    step();
  endtask

  task automatic test_priority();
    irq_in = 8'h22; step(); irq_in = 8'h00; step(); step(); step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL pr_req1 act=%0b exp=1", req); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (ack_idx !== 3'd5) begin errs++; $display("FAIL pr_ackidx1 act=%0d exp=5", ack_idx); end
    vecs++; if (in_svc !== 8'h20) begin errs++; $display("FAIL pr_insvc1 act=%h exp=20", in_svc); end
    vecs++; if (pend !== 8'h02) begin errs++; $display("FAIL pr_pend1 act=%h exp=02", pend); end
    eoi = 1'b1; step(); eoi = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL pr_idle_gap act=%0b exp=0", busy); end
    step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL pr_req2 act=%0b exp=1", req); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (ack_idx !== 3'd1) begin errs++; $display("FAIL pr_ackidx2 act=%0d exp=1", ack_idx); end
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL pr_pend2 act=%h exp=00", pend); end
    eoi = 1'b1; step(); eoi = 1'b0; step();
  endtask

  task automatic test_mask_withdraw();
    irq_in = 8'h40; step(); irq_in = 8'h00; step(); step(); step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL mw_req act=%0b exp=1", req); end
    mask = 8'hBF; #1;
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL mw_pend_masked act=%h exp=00", pend); end
    step();
    vecs++; if (req !== 1'b0) begin errs++; $display("FAIL mw_withdraw act=%0b exp=0", req); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mw_busy act=%0b exp=0", busy); end
    step();
    vecs++; if (req !== 1'b0) begin errs++; $display("FAIL mw_stay_idle act=%0b exp=0", req); end
    mask = 8'hFF; #1;
    vecs++; if (pend !== 8'h40) begin errs++; $display("FAIL mw_pend_kept act=%h exp=40", pend); end
    step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL mw_reissue act=%0b exp=1", req); end
    glb_en = 1'b0; step();
    vecs++; if (req !== 1'b0) begin errs++; $display("FAIL mw_gen_withdraw act=%0b exp=0", req); end
    vecs++; if (enc_en !== 1'b0) begin errs++; $display("FAIL mw_enc_en act=%0b exp=0", enc_en); end
    step();
    vecs++; if (req !== 1'b0) begin errs++; $display("FAIL mw_gen_block act=%0b exp=0", req); end
    glb_en = 1'b1; step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL mw_gen_reissue act=%0b exp=1", req); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (ack_idx !== 3'd6) begin errs++; $display("FAIL mw_ackidx act=%0d exp=6", ack_idx); end
    eoi = 1'b1; step(); eoi = 1'b0; step();
  endtask

  task automatic test_collision();
    irq_in = 8'h04; step(); irq_in = 8'h00; step(); step(); step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL co_req act=%0b exp=1", req); end
    irq_in = 8'h04; step(); irq_in = 8'h00; step();
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (pend !== 8'h04) begin errs++; $display("FAIL co_set_wins act=%h exp=04", pend); end
    vecs++; if (in_svc !== 8'h04) begin errs++; $display("FAIL co_insvc act=%h exp=04", in_svc); end
    vecs++; if (ack_idx !== 3'd2) begin errs++; $display("FAIL co_ackidx act=%0d exp=2", ack_idx); end
    eoi = 1'b1; step(); eoi = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL co_busy act=%0b exp=0", busy); end
    step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL co_req2 act=%0b exp=1", req); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL co_pend_clr act=%h exp=00", pend); end
    eoi = 1'b1; step(); eoi = 1'b0; step();
  endtask

  task automatic test_reset_in_service();
    irq_in = 8'h90; step(); irq_in = 8'h00; step(); step(); step();
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (in_svc !== 8'h80) begin errs++; $display("FAIL ar_insvc act=%h exp=80", in_svc); end
    vecs++; if (pend !== 8'h10) begin errs++; $display("FAIL ar_pend act=%h exp=10", pend); end
    #3 rst_n = 1'b0;
    #1;
    vecs++; if (req !== 1'b0) begin errs++; $display("FAIL ar_req act=%0b exp=0", req); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL ar_busy act=%0b exp=0", busy); end
    vecs++; if (in_svc !== 8'h00) begin errs++; $display("FAIL ar_insvc0 act=%h exp=00", in_svc); end
    vecs++; if (ack_idx !== 3'd0) begin errs++; $display("FAIL ar_ackidx act=%0d exp=0", ack_idx); end
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL ar_pend0 act=%h exp=00", pend); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vecs++; if (req !== 1'b0 || pend !== 8'h00) begin
        errs++; $display("FAIL ar_quiet%0d req=%0b pend=%h exp req=0 pend=00", i, req, pend);
      end
    end
    irq_in = 8'h02; step(); irq_in = 8'h00; step(); step(); step();
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL ar_new_edge act=%0b exp=1", req); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (ack_idx !== 3'd1) begin errs++; $display("FAIL ar_ackidx2 act=%0d exp=1", ack_idx); end
    eoi = 1'b1; step(); eoi = 1'b0; step();
  endtask

  task automatic test_level_mode();
    irq_in0 = 8'h01; step(); step();
    vecs++; if (pend0 !== 8'h01) begin errs++; $display("FAIL lv_pend act=%h exp=01", pend0); end
    vecs++; if (req0 !== 1'b0) begin errs++; $display("FAIL lv_req_early act=%0b exp=0", req0); end
    step();
    vecs++; if (req0 !== 1'b1) begin errs++; $display("FAIL lv_req act=%0b exp=1", req0); end
    for (int n = 0; n < 3; n++) begin
      ack0 = 1'b1; step(); ack0 = 1'b0;
      vecs++; if (ack_idx0 !== 3'd0 || in_svc0 !== 8'h01 || pend0 !== 8'h01) begin
        errs++; $display("FAIL lv_ack%0d idx=%0d insvc=%h pend=%h exp 0/01/01", n, ack_idx0, in_svc0, pend0);
      end
      eoi0 = 1'b1; step(); eoi0 = 1'b0;
      vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL lv_eoi%0d busy act=%0b exp=0", n, busy0); end
      step();
      vecs++; if (req0 !== 1'b1) begin errs++; $display("FAIL lv_rereq%0d act=%0b exp=1", n, req0); end
    end
    irq_in0 = 8'h00; step(); step();
    vecs++; if (req0 !== 1'b1) begin errs++; $display("FAIL lv_req_hold act=%0b exp=1", req0); end
    step();
    vecs++; if (req0 !== 1'b0) begin errs++; $display("FAIL lv_withdraw act=%0b exp=0", req0); end
    vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL lv_busy act=%0b exp=0", busy0); end
    vecs++; if (pend0 !== 8'h00) begin errs++; $display("FAIL lv_pend0 act=%h exp=00", pend0); end
  endtask

  initial begin
    irq_in = '0; irq_in0 = '0; mask = 8'hFF; glb_en = 1'b1;
    ack = 1'b0; eoi = 1'b0; ack0 = 1'b0; eoi0 = 1'b0;
    test_reset();
    test_single_line();
    test_priority();
    test_mask_withdraw();
    test_collision();
    test_reset_in_service();
    test_level_mode();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
